// File: rtl/ofdm_rx_frame_ctrl_pkg.sv
// rtl/ofdm_rx_frame_ctrl_pkg.sv - shared state type and default constants for the OFDM RX frame controller
package ofdm_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SEARCH,
        ST_RECEIVE,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_t;

    localparam int unsigned SEQUENCE_LENGTH_DEF        = 20;
    localparam int unsigned LEVEL_WIDTH_DEF            = 16;
    localparam int unsigned COARSE_ALIGNMENT_LEVEL_DEF = 11000;
    localparam int unsigned INIT_CYCLES_DEF            = 4;
    localparam int unsigned SEARCH_TIMEOUT_DEF         = 65535;
    localparam int unsigned GAP_TIMEOUT_DEF            = 2560;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ofdm_rx_frame_ctrl_if.sv
// rtl/ofdm_rx_frame_ctrl_if.sv - control/status link between the frame controller and the RX datapath
interface ofdm_rx_frame_ctrl_if #(
    parameter int unsigned level_width_c = 16
);
    logic                     align_found;
    logic                     rcv_data_start;
    logic                     rcv_data_valid;
    logic                     dp_init;
    logic [level_width_c-1:0] dp_min_level;

    modport master (
        input  align_found,
        input  rcv_data_start,
        input  rcv_data_valid,
        output dp_init,
        output dp_min_level
    );

    modport slave (
        output align_found,
        output rcv_data_start,
        output rcv_data_valid,
        input  dp_init,
        input  dp_min_level
    );
endinterface

// File: rtl/ofdm_rx_timeout_cnt.sv
// rtl/ofdm_rx_timeout_cnt.sv - free-running supervision timer with a runtime-selected limit
module ofdm_rx_timeout_cnt #(
    parameter int unsigned max_limit_c = 65535,
    parameter int unsigned cnt_width_c = $clog2(max_limit_c + 1)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic [cnt_width_c-1:0] limit,
    output logic                   expired
);
    logic [cnt_width_c-1:0] count_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + cnt_width_c'(1);
        end
    end

    // Flags the last cycle of the window so the owner acts exactly limit cycles after a clear.
    assign expired = en && (count_q == (limit - cnt_width_c'(1)));
endmodule

// File: rtl/ofdm_rx_frame_ctrl.sv
// rtl/ofdm_rx_frame_ctrl.sv - frame-level sequencer: datapath init, threshold programming, symbol counting, timeouts
module ofdm_rx_frame_ctrl
    import ofdm_rx_ctrl_pkg::*;
#(
    parameter int unsigned sequence_length_c        = SEQUENCE_LENGTH_DEF,
    parameter int unsigned level_width_c            = LEVEL_WIDTH_DEF,
    parameter int unsigned coarse_alignment_level_c = COARSE_ALIGNMENT_LEVEL_DEF,
    parameter int unsigned init_cycles_c            = INIT_CYCLES_DEF,
    parameter int unsigned search_timeout_c         = SEARCH_TIMEOUT_DEF,
    parameter int unsigned gap_timeout_c            = GAP_TIMEOUT_DEF,
    parameter int unsigned sym_width_c              = $clog2(sequence_length_c + 1)
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     enable,
    input  logic [level_width_c-1:0] cfg_min_level,
    input  logic                     cfg_load,
    ofdm_rx_frame_ctrl_if.master     dp,
    output logic                     frame_active,
    output logic [sym_width_c-1:0]   sym_count,
    output logic                     frame_done,
    output logic                     timeout_err
);
    localparam int unsigned tmr_max_c   = max_u(search_timeout_c, gap_timeout_c);
    localparam int unsigned tmr_width_c = $clog2(tmr_max_c + 1);
    localparam int unsigned init_width_c = $clog2(init_cycles_c + 1);

    ctrl_state_t state_q, state_d;
    logic [init_width_c-1:0]  init_cnt_q;
    logic [level_width_c-1:0] shadow_q;
    logic [tmr_width_c-1:0]   tmr_limit;
    logic tmr_clear, tmr_en, tmr_expired;
    logic sym_inc, timeout_d, init_entry, rcv_entry;

    assign tmr_limit = (state_q == ST_SEARCH) ? tmr_width_c'(search_timeout_c)
                                              : tmr_width_c'(gap_timeout_c);

    ofdm_rx_timeout_cnt #(
        .max_limit_c (tmr_max_c),
        .cnt_width_c (tmr_width_c)
    ) u_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        tmr_clear = 1'b1;
        tmr_en    = 1'b0;
        sym_inc   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (init_cnt_q == init_width_c'(init_cycles_c - 1)) state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                tmr_clear = 1'b0;
                tmr_en    = 1'b1;
                if (dp.align_found) begin
                    state_d   = ST_RECEIVE;
                    tmr_clear = 1'b1;
                end else if (tmr_expired) begin
                    state_d   = ST_INIT;
                    timeout_d = 1'b1;
                end
            end
            ST_RECEIVE: begin
                tmr_clear = 1'b0;
                tmr_en    = 1'b1;
                // A start in the same cycle as expiry counts as activity and beats the timeout.
                if (dp.rcv_data_start) begin
                    sym_inc   = 1'b1;
                    tmr_clear = 1'b1;
                    if (sym_count == sym_width_c'(sequence_length_c - 1)) state_d = ST_DRAIN;
                end else if (tmr_expired) begin
                    state_d   = ST_INIT;
                    timeout_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                tmr_clear = 1'b0;
                tmr_en    = 1'b1;
                if (!dp.rcv_data_valid) begin
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    state_d   = ST_INIT;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = enable ? ST_INIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b0;
            sym_inc   = 1'b0;
        end
    end

    assign init_entry = (state_d == ST_INIT) && (state_q != ST_INIT);
    assign rcv_entry  = (state_d == ST_RECEIVE) && (state_q == ST_SEARCH);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q         <= ST_IDLE;
            init_cnt_q      <= '0;
            shadow_q        <= level_width_c'(coarse_alignment_level_c);
            dp.dp_min_level <= level_width_c'(coarse_alignment_level_c);
            dp.dp_init      <= 1'b1;
            frame_active    <= 1'b0;
            sym_count       <= '0;
            frame_done      <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_load) shadow_q <= cfg_min_level;
            // Threshold only moves at INIT entry; a write landing on that edge is taken directly.
            if (init_entry) dp.dp_min_level <= cfg_load ? cfg_min_level : shadow_q;
            if ((state_q == ST_INIT) && (state_d == ST_INIT)) begin
                init_cnt_q <= init_cnt_q + init_width_c'(1);
            end else begin
                init_cnt_q <= '0;
            end
            if (init_entry || rcv_entry) begin
                sym_count <= '0;
            end else if (sym_inc && (sym_count != sym_width_c'(sequence_length_c))) begin
                sym_count <= sym_count + sym_width_c'(1);
            end
            dp.dp_init   <= (state_d == ST_IDLE) || (state_d == ST_INIT);
            frame_active <= (state_d == ST_RECEIVE);
            frame_done   <= (state_d == ST_DONE);
            timeout_err  <= timeout_d;
        end
    end
endmodule
